fetch_stage: RTL and testbench

- Pipelined instruction-fetch stage: owns the PC, drives a variable-latency instruction-memory request/ready handshake, and loads the IF/ID pipeline register consumed by the decode/control stage.
- Sits directly upstream of decode in the 16-bit processor and replaces the combinational IF path when the datapath is pipelined.
- Handles decode stalls through a one-entry skid buffer.
- Handles branch/jump redirects, including squashing a fetch that is already in flight.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_skid_buffer.sv | 39 +++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the pipelined instruction-fetch stage.
package fetch_pkg;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 16;

   localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      HOLD,
      DISCARD
   } fetchState_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage and memory.
interface fetch_stage_if;
   import fetch_pkg::*;

   logic               imemReq;
   logic [PC_W-1:0]    imemAddr;
   logic               imemReady;
   logic [INSTR_W-1:0] imemData;

   modport master (output imemReq, output imemAddr, input imemReady, input imemData);
   modport slave  (input imemReq, input imemAddr, output imemReady, output imemData);

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pcNext} holding register that catches a response arriving during a decode stall.
module fetch_skid_buffer
   import fetch_pkg::*;
(
   input  logic               clock,
   input  logic               resetN,
   input  logic               load,
   input  logic               clear,
   input  logic [INSTR_W-1:0] instrIn,
   input  logic [PC_W-1:0]    pcNextIn,
   output logic               full,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pcNext
);

   logic               fullReg;
   logic [INSTR_W-1:0] instrReg;
   logic [PC_W-1:0]    pcNextReg;

   // Clear wins over load so a redirect can never leave a stale entry behind.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         fullReg   <= 1'b0;
         instrReg  <= '0;
         pcNextReg <= '0;
      end else if (clear) begin
         fullReg <= 1'b0;
      end else if (load) begin
         fullReg   <= 1'b1;
         instrReg  <= instrIn;
         pcNextReg <= pcNextIn;
      end
   end

   assign full   = fullReg;
   assign instr  = instrReg;
   assign pcNext = pcNextReg;

endmodule

// File: rtl/fetch_stage.sv
// Pipelined fetch stage: owns the PC, drives the imem handshake and loads IF/ID.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
   parameter logic [PC_W-1:0]    PC_STEP   = 16'd2,
   parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic               clock,
   input  logic               resetN,
   fetch_stage_if.master      imem,
   input  logic               stall,
   input  logic               branchTaken,
   input  logic [PC_W-1:0]    branchTarget,
   input  logic               jump,
   input  logic [PC_W-1:0]    jumpTarget,
   output logic               ifidValid,
   output logic [INSTR_W-1:0] ifidInstruction,
   output logic [PC_W-1:0]    ifidPCNext,
   output logic [PC_W-1:0]    fetchPC
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perfFetched,
   output logic [31:0]        perfSquashed
`endif
);

   fetchState_e        stateReg, stateNext;
   logic [PC_W-1:0]    pcReg, pcNext;
   logic [PC_W-1:0]    redirectPCReg, redirectPCNext;
   logic               ifidValidReg, ifidValidNext;
   logic [INSTR_W-1:0] ifidInstrReg, ifidInstrNext;
   logic [PC_W-1:0]    ifidPCNextReg, ifidPCNextNext;

   logic               redirect;
   logic [PC_W-1:0]    redirectTarget;
   logic [PC_W-1:0]    pcPlusStep;

   logic               skidLoad, skidClear, skidFull;
   logic [INSTR_W-1:0] skidInstr;
   logic [PC_W-1:0]    skidPCNext;

   assign redirect       = jump | branchTaken;
   assign redirectTarget = jump ? jumpTarget : branchTarget;
   assign pcPlusStep     = pcReg + PC_STEP;

   fetch_skid_buffer skid (
      .clock    (clock),
      .resetN   (resetN),
      .load     (skidLoad),
      .clear    (skidClear),
      .instrIn  (imem.imemData),
      .pcNextIn (pcPlusStep),
      .full     (skidFull),
      .instr    (skidInstr),
      .pcNext   (skidPCNext)
   );

   always_ff @(posedge clock) begin
      if (!resetN) begin
         stateReg      <= BOOT;
         pcReg         <= RESET_PC;
         redirectPCReg <= '0;
         ifidValidReg  <= 1'b0;
         ifidInstrReg  <= NOP_INSTR;
         ifidPCNextReg <= '0;
      end else begin
         stateReg      <= stateNext;
         pcReg         <= pcNext;
         redirectPCReg <= redirectPCNext;
         ifidValidReg  <= ifidValidNext;
         ifidInstrReg  <= ifidInstrNext;
         ifidPCNextReg <= ifidPCNextNext;
      end
   end

   always_comb begin
      stateNext      = stateReg;
      pcNext         = pcReg;
      redirectPCNext = redirectPCReg;
      ifidValidNext  = ifidValidReg;
      ifidInstrNext  = ifidInstrReg;
      ifidPCNextNext = ifidPCNextReg;
      skidLoad       = 1'b0;
      skidClear      = 1'b0;

      case (stateReg)
         BOOT: begin
            stateNext = FETCH;
            if (redirect) pcNext = redirectTarget;
         end
         FETCH: begin
            if (redirect) begin
               if (imem.imemReady) begin
                  pcNext = redirectTarget;
               end else begin
                  redirectPCNext = redirectTarget;
                  stateNext      = DISCARD;
               end
            end else if (imem.imemReady) begin
               pcNext = pcPlusStep;
               if (stall) begin
                  skidLoad  = 1'b1;
                  stateNext = HOLD;
               end else begin
                  ifidValidNext  = 1'b1;
                  ifidInstrNext  = imem.imemData;
                  ifidPCNextNext = pcPlusStep;
               end
            end else if (!stall) begin
               ifidValidNext = 1'b0;
               ifidInstrNext = NOP_INSTR;
            end
         end
         HOLD: begin
            if (redirect) begin
               pcNext    = redirectTarget;
               stateNext = FETCH;
            end else if (!stall) begin
               ifidValidNext  = skidFull;
               ifidInstrNext  = skidInstr;
               ifidPCNextNext = skidPCNext;
               skidClear      = 1'b1;
               stateNext      = FETCH;
            end
         end
         DISCARD: begin
            // A redirect arriving together with the completion is the newest one.
            if (redirect) redirectPCNext = redirectTarget;
            if (imem.imemReady) begin
               pcNext    = redirect ? redirectTarget : redirectPCReg;
               stateNext = FETCH;
            end
         end
         default: stateNext = BOOT;
      endcase

      if (redirect) begin
         ifidValidNext = 1'b0;
         ifidInstrNext = NOP_INSTR;
         skidClear     = 1'b1;
      end
   end

   // pc is not advanced until a squashed request completes, so it still holds the old address.
   assign imem.imemReq    = (stateReg == FETCH) || (stateReg == DISCARD);
   assign imem.imemAddr   = pcReg;
   assign ifidValid       = ifidValidReg;
   assign ifidInstruction = ifidInstrReg;
   assign ifidPCNext      = ifidPCNextReg;
   assign fetchPC         = pcReg;

`ifdef FETCH_PERF_CNT_EN
   logic        fetchEvent, squashEvent;
   logic [31:0] perfFetchedReg, perfSquashedReg;

   always_comb begin
      fetchEvent  = !redirect && !stall &&
                    (((stateReg == FETCH) && imem.imemReady) || ((stateReg == HOLD) && skidFull));
      squashEvent = ((stateReg == FETCH) && redirect && imem.imemReady) ||
                    ((stateReg == DISCARD) && imem.imemReady) ||
                    (redirect && skidFull);
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         perfFetchedReg  <= '0;
         perfSquashedReg <= '0;
      end else begin
         if (fetchEvent)  perfFetchedReg  <= perfFetchedReg + 32'd1;
         if (squashEvent) perfSquashedReg <= perfSquashedReg + 32'd1;
      end
   end

   assign perfFetched  = perfFetchedReg;
   assign perfSquashed = perfSquashedReg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized phase checked by an instruction-stream model.
module tb_fetch_stage;

   localparam logic [15:0] NOP    = 16'h0000;
   localparam logic [15:0] RST_PC = 16'h0000;

   logic        clock = 1'b0;
   logic        resetN;
   logic        stall, branchTaken, jump;
   logic [15:0] branchTarget, jumpTarget;
   logic        ifidValid, ifidValid2;
   logic [15:0] ifidInstruction, ifidPCNext, fetchPC;
   logic [15:0] ifidInstruction2, ifidPCNext2, fetchPC2;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perfFetched, perfSquashed, perfFetched2, perfSquashed2;
`endif

   fetch_stage_if imem ();
   fetch_stage_if imem2 ();

   always #5 clock = ~clock;

   fetch_stage dut (
      .clock           (clock),
      .resetN          (resetN),
      .imem            (imem),
      .stall           (stall),
      .branchTaken     (branchTaken),
      .branchTarget    (branchTarget),
      .jump            (jump),
      .jumpTarget      (jumpTarget),
      .ifidValid       (ifidValid),
      .ifidInstruction (ifidInstruction),
      .ifidPCNext      (ifidPCNext),
      .fetchPC         (fetchPC)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perfFetched     (perfFetched),
      .perfSquashed    (perfSquashed)
`endif
   );

   fetch_stage #(.RESET_PC(16'hFFFE)) dutWrap (
      .clock           (clock),
      .resetN          (resetN),
      .imem            (imem2),
      .stall           (stall),
      .branchTaken     (branchTaken),
      .branchTarget    (branchTarget),
      .jump            (jump),
      .jumpTarget      (jumpTarget),
      .ifidValid       (ifidValid2),
      .ifidInstruction (ifidInstruction2),
      .ifidPCNext      (ifidPCNext2),
      .fetchPC         (fetchPC2)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perfFetched     (perfFetched2),
      .perfSquashed    (perfSquashed2)
`endif
   );

   int passCnt = 0;
   int totalCnt = 0;
   int waitStates = 0;
   int waitCnt = 0;
   int waitCnt2 = 0;
   int nValid = 0;
   int nValidSinceRst = 0;

   // stimulus values applied by the next step()
   logic        rstNV = 1'b0, stallV = 1'b0, branchV = 1'b0, jumpV = 1'b0;
   logic [15:0] btgtV = '0, jtgtV = '0;

   // instruction-stream reference model
   logic [15:0] expAddr = RST_PC;
   logic        pendValid = 1'b0;
   logic [15:0] pendAddr = '0;

   function automatic logic [15:0] memFn(input logic [15:0] a);
      return a + 16'h1000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drive inputs and memory responses, advance one clock, then check against the model.
   task automatic step();
      logic        pRst, pRedir, pStall, pReady, pReq, prevV, newReq;
      logic [15:0] pTarget, pAddr, prevI, prevP;
      resetN       = rstNV;
      stall        = stallV;
      branchTaken  = branchV;
      branchTarget = btgtV;
      jump         = jumpV;
      jumpTarget   = jtgtV;
      if (imem.imemReq) begin
         if (waitCnt >= waitStates) begin
            imem.imemReady = 1'b1; imem.imemData = memFn(imem.imemAddr); waitCnt = 0;
         end else begin
            imem.imemReady = 1'b0; imem.imemData = 16'hDEAD; waitCnt++;
         end
      end else begin
         imem.imemReady = 1'b0; imem.imemData = 16'hDEAD; waitCnt = 0;
      end
      if (imem2.imemReq) begin
         if (waitCnt2 >= waitStates) begin
            imem2.imemReady = 1'b1; imem2.imemData = memFn(imem2.imemAddr); waitCnt2 = 0;
         end else begin
            imem2.imemReady = 1'b0; imem2.imemData = 16'hDEAD; waitCnt2++;
         end
      end else begin
         imem2.imemReady = 1'b0; imem2.imemData = 16'hDEAD; waitCnt2 = 0;
      end
      pRst    = !rstNV;
      pRedir  = branchV | jumpV;
      pTarget = jumpV ? jtgtV : btgtV;
      pStall  = stallV;
      pReady  = imem.imemReady;
      pReq    = imem.imemReq;
      pAddr   = imem.imemAddr;
      prevV   = ifidValid;
      prevI   = ifidInstruction;
      prevP   = ifidPCNext;
      @(posedge clock);
      #1;
      if (pRst) begin
         chk("rst_pc", fetchPC, RST_PC);
         chk("rst_req", imem.imemReq, 1'b0);
         chk("rst_valid", ifidValid, 1'b0);
         chk("rst_instr", ifidInstruction, NOP);
         chk("rst_pcnext", ifidPCNext, 16'h0000);
         expAddr = RST_PC; pendValid = 1'b1; pendAddr = RST_PC; nValidSinceRst = 0;
      end else begin
         if (pReq && !pReady) begin
            chk("req_held", imem.imemReq, 1'b1);
            chk("addr_stable", imem.imemAddr, pAddr);
         end
         if (pRedir) begin
            chk("redir_valid", ifidValid, 1'b0);
            chk("redir_instr", ifidInstruction, NOP);
            expAddr = pTarget; pendValid = 1'b1; pendAddr = pTarget;
         end else if (pStall) begin
            chk("stall_valid", ifidValid, prevV);
            chk("stall_instr", ifidInstruction, prevI);
            chk("stall_pcnext", ifidPCNext, prevP);
         end else if (ifidValid) begin
            chk("stream_pcnext", ifidPCNext, expAddr + 16'd2);
            chk("stream_instr", ifidInstruction, memFn(expAddr));
            expAddr = expAddr + 16'd2;
            nValid++; nValidSinceRst++;
         end else begin
            chk("bubble_instr", ifidInstruction, NOP);
         end
         newReq = imem.imemReq && (!pReq || pReady);
         if (newReq && pendValid) begin
            chk("redir_addr", imem.imemAddr, pendAddr);
            pendValid = 1'b0;
         end
      end
   endtask

   initial begin
      logic [15:0] base;
      int r;

      // reset
      rstNV = 1'b0;
      step();
      step();

      // zero-wait streaming
      waitStates = 0;
      rstNV = 1'b1;
      step();
      chk("t1_req", imem.imemReq, 1'b1);
      chk("t1_addr0", imem.imemAddr, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t1_valid", ifidValid, 1'b1);
         chk("t1_instr", ifidInstruction, 16'h1000 + 16'(2 * k));
         chk("t1_pcnext", ifidPCNext, 16'(2 * k + 2));
         chk("t1_addr", imem.imemAddr, 16'(2 * k + 2));
      end

      // two wait states: valid 0,0,1 and address held during waits
      waitStates = 2;
      base = imem.imemAddr;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("t2_valid", ifidValid, (k % 3 == 2) ? 1'b1 : 1'b0);
         chk("t2_addr", imem.imemAddr, base + 16'(2 * ((k + 1) / 3)));
      end

      // decode stall while the response for 0x0004 arrives
      rstNV = 1'b0;
      step();
      rstNV = 1'b1;
      waitStates = 0;
      step();
      step();
      step();
      chk("t3_pre_addr", imem.imemAddr, 16'h0004);
      stallV = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t3_req_off", imem.imemReq, 1'b0);
         chk("t3_hold_instr", ifidInstruction, 16'h1002);
         chk("t3_hold_pcnext", ifidPCNext, 16'h0004);
      end
      stallV = 1'b0;
      step();
      chk("t3_rel_instr", ifidInstruction, 16'h1004);
      chk("t3_rel_valid", ifidValid, 1'b1);
      chk("t3_rel_addr", imem.imemAddr, 16'h0006);
      step();
      chk("t3_next_instr", ifidInstruction, 16'h1006);

      // branch while the request to 0x0008 is waiting
      waitStates = 3;
      step();
      branchV = 1'b1; btgtV = 16'h0040;
      step();
      branchV = 1'b0;
      chk("t4_disc_addr", imem.imemAddr, 16'h0008);
      chk("t4_disc_valid", ifidValid, 1'b0);
      step();
      chk("t4_disc_addr2", imem.imemAddr, 16'h0008);
      step();
      chk("t4_new_addr", imem.imemAddr, 16'h0040);
      chk("t4_new_valid", ifidValid, 1'b0);
      waitStates = 0;
      step();
      chk("t4_tgt_instr", ifidInstruction, 16'h1040);

      // jump and branch together with stall: jump wins
      jumpV = 1'b1; jtgtV = 16'h0100; branchV = 1'b1; btgtV = 16'h0040; stallV = 1'b1;
      step();
      jumpV = 1'b0; branchV = 1'b0; stallV = 1'b0;
      chk("t5_addr", imem.imemAddr, 16'h0100);
      chk("t5_valid", ifidValid, 1'b0);
      step();
      chk("t5_instr", ifidInstruction, 16'h1100);

      // randomized traffic against the stream model
      for (int i = 0; i < 1500; i++) begin
         if (i % 40 == 0) waitStates = $urandom_range(0, 3);
         stallV  = ($urandom_range(0, 99) < 30);
         r       = $urandom_range(0, 99);
         branchV = (r < 6);
         jumpV   = (r >= 4 && r < 8);
         btgtV   = 16'($urandom) & 16'hFFFE;
         jtgtV   = 16'($urandom) & 16'hFFFE;
         step();
      end
      stallV = 1'b0; branchV = 1'b0; jumpV = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("rand_progress", (nValid > 200) ? 1'b1 : 1'b0, 1'b1);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perfFetched, 32'(nValidSinceRst));
`endif

      // PC wrap from RESET_PC=0xFFFE, then reset during a wait
      rstNV = 1'b0;
      step();
      rstNV = 1'b1;
      waitStates = 0;
      step();
      chk("t6_addr0", imem2.imemAddr, 16'hFFFE);
      step();
      chk("t6_addr1", imem2.imemAddr, 16'h0000);
      chk("t6_instr", ifidInstruction2, 16'h0FFE);
      waitStates = 3;
      step();
      step();
      chk("t6_waiting", imem2.imemReq, 1'b1);
      rstNV = 1'b0;
      step();
      chk("t6_rst_pc", fetchPC2, 16'hFFFE);
      chk("t6_rst_req", imem2.imemReq, 1'b0);
      chk("t6_rst_valid", ifidValid2, 1'b0);
      rstNV = 1'b1;
      step();
      step();

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
